writeback_unit: RTL

- Register-file write-side controller for the multi-cycle RV32I core; the producer end of the decoder's regWrite/writeData/rd interface.
- Accepts one retiring instruction per handshake from execute. Selects ALU result, PC+4, or a memory load. For loads it issues the data-memory read, waits for the response, then byte/half-selects and sign/zero-extends.
- Drives a single-cycle register-file write strobe.

---
 rtl/core_pkg.sv | 34 +++
 rtl/writeback_unit_load_extend.sv | 28 ++
 rtl/writeback_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: writeback select encodings, load funct3 codes,
// writeback FSM state type and the load alignment rule.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_NONE = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef logic [1:0] wb_state_t;

  localparam wb_state_t ST_IDLE  = 2'd0;
  localparam wb_state_t ST_REQ   = 2'd1;
  localparam wb_state_t ST_WAIT  = 2'd2;
  localparam wb_state_t ST_WRITE = 2'd3;

  // Byte loads and unknown funct3 codes (full-word writes) are never misaligned.
  function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] addr);
    case (f3)
      F3_LH, F3_LHU: return addr[0];
      F3_LW:         return addr != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/writeback_unit_load_extend.sv
// load_extend: combinational byte/half lane select with sign or zero extension.
// Shared by the writeback unit and the LSU.
module load_extend #(
  parameter int XLEN = core_pkg::XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] value
);
  import core_pkg::*;

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{addr, 3'b000} +: 8];
    half_lane = addr[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   value = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_LBU:  value = {{(XLEN-8){1'b0}}, byte_lane};
      F3_LH:   value = {{(XLEN-16){half_lane[15]}}, half_lane};
      F3_LHU:  value = {{(XLEN-16){1'b0}}, half_lane};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: register-file write controller (ALU / PC+4 / memory load).
// Optional memory wait timeout enabled by defining WB_MEM_TIMEOUT_EN.
module writeback_unit #(
  parameter int XLEN = core_pkg::XLEN
`ifdef WB_MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      wb_sel,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] pc_plus4,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            reg_write,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] write_data,
`ifdef WB_MEM_TIMEOUT_EN
  output logic            mem_timeout,
`endif
  output logic            misaligned
);
  import core_pkg::*;

  wb_state_t       state;
  logic            ready_q;
  logic            mis_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] load_value;
  logic            load_done;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3(f3_q),
    .addr  (addr_q[1:0]),
    .word  (mem_rdata),
    .value (load_value)
  );

  assign load_done = ((state == ST_REQ) && mem_gnt && mem_rvalid) ||
                     ((state == ST_WAIT) && mem_rvalid);

  // ready_q keeps in_ready low for the first cycle out of reset.
  assign in_ready   = ready_q && (state == ST_IDLE);
  assign mem_req    = (state == ST_REQ);
  assign mem_addr   = {addr_q[XLEN-1:2], 2'b00};
  assign reg_write  = (state == ST_WRITE) && (rd_q != 5'd0);
  assign rd_out     = (state == ST_WRITE) ? rd_q : 5'd0;
  assign write_data = (state == ST_WRITE) ? data_q : '0;
  assign misaligned = mis_q;

`ifdef WB_MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_cnt;
  logic             tmo_q;
  logic             timeout_hit;

  assign timeout_hit = ((state == ST_REQ) || (state == ST_WAIT)) && !load_done &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign mem_timeout = tmo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      tmo_q    <= 1'b0;
    end else begin
      tmo_q <= timeout_hit;
      if (((state == ST_REQ) || (state == ST_WAIT)) && !load_done && !timeout_hit)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ready_q <= 1'b0;
      mis_q   <= 1'b0;
      f3_q    <= '0;
      rd_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      ready_q <= 1'b1;
      mis_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid && ready_q) begin
            f3_q   <= funct3;
            rd_q   <= rd;
            addr_q <= alu_result;
            case (wb_sel)
              WB_ALU: begin
                data_q <= alu_result;
                state  <= ST_WRITE;
              end
              WB_PC4: begin
                data_q <= pc_plus4;
                state  <= ST_WRITE;
              end
              WB_MEM: begin
                if (load_misaligned(funct3, alu_result[1:0])) mis_q <= 1'b1;
                else                                          state <= ST_REQ;
              end
              WB_NONE: ;
            endcase
          end
        end
        ST_REQ: begin
          if (load_done) begin
            data_q <= load_value;
            state  <= ST_WRITE;
          end else if (mem_gnt) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (load_done) begin
            data_q <= load_value;
            state  <= ST_WRITE;
          end
        end
        default: state <= ST_IDLE;
      endcase
`ifdef WB_MEM_TIMEOUT_EN
      // A stalled memory abandons the load without touching the register file.
      if (timeout_hit) state <= ST_IDLE;
`endif
    end
  end

endmodule
